// File: rtl/pc_seq_pkg.sv
// +----------------------------------------------------------------------+
// | pc_seq_pkg : shared types and defaults for the PC sequencer          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package pc_seq_pkg;

  localparam int unsigned DEF_ADDR_W    = 16;
  localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
  localparam logic [15:0] DEF_IRQ_VEC   = 16'h0010;
  localparam int unsigned DEF_RAS_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_BR   = 3'd1,
    SRC_CALL = 3'd2,
    SRC_RET  = 3'd3,
    SRC_IRQ  = 3'd4,
    SRC_HLT  = 3'd5
  } src_e;

  // Fixed priority: hlt > irq > ret > call > br > sequential.
  function automatic src_e pick_src(input logic hlt, input logic irq, input logic ret,
                                    input logic call, input logic br);
    src_e s;
    s = SRC_SEQ;
    if (hlt)       s = SRC_HLT;
    else if (irq)  s = SRC_IRQ;
    else if (ret)  s = SRC_RET;
    else if (call) s = SRC_CALL;
    else if (br)   s = SRC_BR;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ras_stack.sv
// +----------------------------------------------------------------------+
// | ras_stack : LIFO return-address stack, count 0..RAS_DEPTH            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ras_stack #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_idx, top_idx;

  assign full    = (count_q == CNT_W'(RAS_DEPTH));
  assign empty   = (count_q == '0);
  // When full the low bits wrap to 0, so top_idx still lands on the last entry.
  assign wr_idx  = count_q[PTR_W-1:0];
  assign top_idx = wr_idx - PTR_W'(1);
  assign dout    = mem_q[top_idx];

  always_comb begin
    count_d = count_q;
    if (push && !full)       count_d = count_q + CNT_W'(1);
    else if (pop && !empty)  count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem_q[wr_idx] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// +----------------------------------------------------------------------+
// | pc_sequencer : fetch / next-PC controller with return-address stack  |
// | Optional interrupt entry via macro PC_SEQ_IRQ_EN.   Rev 1.0          |
// +----------------------------------------------------------------------+
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter int unsigned       RAS_DEPTH = DEF_RAS_DEPTH
`ifdef PC_SEQ_IRQ_EN
  ,
  parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(DEF_IRQ_VEC)
`endif
) (
  input  logic              clock,
  input  logic              reset,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ready,
  input  logic              dec_valid,
  input  logic              dec_hlt,
  input  logic              dec_call,
  input  logic              dec_ret,
  input  logic              dec_br,
  input  logic [ADDR_W-1:0] dec_target,
`ifdef PC_SEQ_IRQ_EN
  input  logic              irq,
`endif
  input  logic              resume,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              ras_ovf,
  output logic              ras_unf
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, nxt;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              load, irq_w;
  src_e              src;
  logic              ras_push, ras_pop, ras_full, ras_empty;
  logic [ADDR_W-1:0] ras_din, ras_dout;

`ifdef PC_SEQ_IRQ_EN
  assign irq_w = irq;
`else
  assign irq_w = 1'b0;
`endif

  assign pc_inc      = pc_q + ADDR_W'(1);
  assign src         = pick_src(dec_hlt, irq_w, dec_ret, dec_call, dec_br);
  // The reset term keeps the request low while reset is held.
  assign fetch_valid = reset && (state_q == ST_FETCH);
  assign fetch_addr  = pc_q;
  assign pc          = pc_q;
  assign halted      = (state_q == ST_HALTED);
  assign pc_load     = load;
  assign pc_next     = load ? nxt : '0;
  assign ras_ovf     = ovf_q;
  assign ras_unf     = unf_q;

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock (clock),
    .reset (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (ras_din),
    .dout  (ras_dout),
    .full  (ras_full),
    .empty (ras_empty)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    load     = 1'b0;
    nxt      = pc_inc;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ras_din  = pc_inc;
    case (state_q)
      ST_FETCH: if (fetch_ready) state_d = ST_EXEC;
      ST_EXEC: if (dec_valid) begin
        load    = 1'b1;
        state_d = ST_FETCH;
        case (src)
          SRC_HLT:  state_d = ST_HALTED;
          SRC_RET:  if (!ras_empty) begin
                      nxt     = ras_dout;
                      ras_pop = 1'b1;
                    end else begin
                      unf_d   = 1'b1;
                    end
          SRC_CALL: begin
                      nxt = dec_target;
                      if (ras_full) ovf_d    = 1'b1;
                      else          ras_push = 1'b1;
                    end
          SRC_BR:   nxt = dec_target;
`ifdef PC_SEQ_IRQ_EN
          SRC_IRQ:  begin
                      nxt = IRQ_VEC;
                      // An interrupted RET leaves its return address on the stack.
                      if (!(dec_ret && !ras_empty)) begin
                        ras_din = (!dec_ret && (dec_call || dec_br)) ? dec_target : pc_inc;
                        if (dec_ret) unf_d = 1'b1;
                        if (ras_full) ovf_d    = 1'b1;
                        else          ras_push = 1'b1;
                      end
                    end
`endif
          default:  nxt = pc_inc;
        endcase
        pc_d = nxt;
      end
      ST_HALTED: begin
`ifdef PC_SEQ_IRQ_EN
        if (irq_w) begin
          load    = 1'b1;
          nxt     = IRQ_VEC;
          pc_d    = IRQ_VEC;
          ras_din = pc_q;
          state_d = ST_FETCH;
          if (ras_full) ovf_d    = 1'b1;
          else          ras_push = 1'b1;
        end else
`endif
        if (resume) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_VEC;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

`default_nettype wire
